// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizing and
// the encoding of the bulk-clear sequencer states.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Bulk-clear sequencer: walks an index over every register, one per cycle,
// then holds DONE for a single cycle before returning to IDLE.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_start,
    output logic          clr_strobe,
    output logic [AW-1:0] clr_idx,
    output clr_state_e    state
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLR_IDLE;
            clr_idx <= '0;
        end else begin
            case (state)
                CLR_IDLE: begin
                    if (clr_req) begin
                        state   <= CLR_CLEAR;
                        clr_idx <= '0;
                    end
                end
                CLR_CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == AW'(NREG - 1))
                        state <= CLR_DONE;
                end
                CLR_DONE: state <= CLR_IDLE;
                default:  state <= CLR_IDLE;
            endcase
        end
    end

    // clr_start marks the IDLE->CLEAR edge, when the whole scoreboard is wiped.
    assign clr_start  = (state == CLR_IDLE) && clr_req;
    assign clr_strobe = (state == CLR_CLEAR);
    assign clr_done   = (state == CLR_DONE);
    assign clr_busy   = (state != CLR_IDLE);

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, same-cycle write
// forwarding, a per-register pending scoreboard and a sequenced bulk clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN    = XLEN_DEF,
    parameter  int NREG    = NREG_DEF,
    parameter  int NRD     = NRD_DEF,
    parameter  int ZERO_R0 = 1,
    parameter  int BYPASS  = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREG-1:0]     pend,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output clr_state_e          clr_state
);

    logic [XLEN-1:0] regs [NREG];
    logic            clr_start;
    logic            clr_strobe;
    logic [AW-1:0]   clr_idx;
    logic            wr_acc;
    logic            rsv_acc;

    regfile_clr_seq #(.NREG(NREG)) u_clr_seq (
        .clk        (clk),
        .reset      (reset),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .clr_start  (clr_start),
        .clr_strobe (clr_strobe),
        .clr_idx    (clr_idx),
        .state      (clr_state)
    );

    // Address 0 is filtered here so neither storage nor pend[0] can ever change.
    assign wr_acc  = wr_en  && !clr_busy && !((ZERO_R0 != 0) && (wr_addr  == '0));
    assign rsv_acc = rsv_en && !clr_busy && !((ZERO_R0 != 0) && (rsv_addr == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (clr_strobe) begin
            regs[clr_idx] <= '0;
        end else if (wr_acc) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Reservation is applied after the write so it wins on an address match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= '0;
        end else if (clr_start) begin
            pend <= '0;
        end else begin
            if (wr_acc)
                pend[wr_addr] <= 1'b0;
            if (rsv_acc)
                pend[rsv_addr] <= 1'b1;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rd_addr[g*AW +: AW];

        always_comb begin
            data = regs[addr];
            if ((BYPASS != 0) && wr_acc && (addr == wr_addr))
                data = wr_data;
            if ((ZERO_R0 != 0) && (addr == '0))
                data = '0;
        end

        assign rd_data[g*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default configuration plus a 16x64, 3-port build.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default configuration: XLEN=32, NREG=32, NRD=2
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [31:0] pend;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;
    clr_state_e  clr_state;

    // Sweep configuration: XLEN=64, NREG=16, NRD=3
    logic [11:0]  rd_addr2;
    logic [191:0] rd_data2;
    logic         wr_en2;
    logic [3:0]   wr_addr2;
    logic [63:0]  wr_data2;
    logic         rsv_en2;
    logic [3:0]   rsv_addr2;
    logic [15:0]  pend2;
    logic         clr_req2;
    logic         clr_busy2;
    logic         clr_done2;
    clr_state_e   clr_state2;

    regfile_mp dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend(pend),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
        .clr_state(clr_state)
    );

    regfile_mp #(.XLEN(64), .NREG(16), .NRD(3)) dut2 (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .rsv_en(rsv_en2), .rsv_addr(rsv_addr2), .pend(pend2),
        .clr_req(clr_req2), .clr_busy(clr_busy2), .clr_done(clr_done2),
        .clr_state(clr_state2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle1();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic fill1();
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000_0000 | 32'(i);
            @(negedge clk);
        end
        idle1();
    endtask

    task automatic idle2();
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
        rsv_en2 = 1'b0; rsv_addr2 = '0; clr_req2 = 1'b0;
    endtask

    task automatic rd2(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
        rd_addr2 = {a2, a1, a0};
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr_en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rsv_en;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] ep;
    } vec_t;

    vec_t vt [13];

    initial begin
        #100000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int busy_n;
        int done_n;
        int done_c;

        // Expected pend is the value before the edge of that cycle.
        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
        vt[2]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
        vt[4]  = '{1'b1, 5'd7,  32'h77,       1'b0, 5'd0,  5'd7,  5'd5,  32'h77,       32'hDEADBEEF, 32'h80};
        vt[5]  = '{1'b1, 5'd9,  32'h99,       1'b1, 5'd9,  5'd9,  5'd7,  32'h99,       32'h77,       32'h0};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'h99,       32'h99,       32'h200};
        vt[7]  = '{1'b1, 5'd3,  32'hA5A5,     1'b0, 5'd0,  5'd3,  5'd2,  32'hA5A5,     32'h0,        32'h200};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd9,  32'hA5A5,     32'h99,       32'h200};
        vt[9]  = '{1'b1, 5'd9,  32'h100,      1'b0, 5'd0,  5'd9,  5'd3,  32'h100,      32'hA5A5,     32'h200};
        vt[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd31, 32'h100,      32'h0,        32'h0};
        vt[11] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd30, 5'd31, 5'd1,  32'hFFFFFFFF, 32'h0,        32'h0};
        vt[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        32'h40000000};

        // ---------------- reset ----------------
        reset = 1'b0;
        idle1(); rd1(5'd5, 5'd31);
        idle2(); rd2(4'd0, 4'd5, 4'd15);
        @(negedge clk);
        #2;
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_rd1", rd_data[63:32], 32'h0);
        chk("rst_pend", pend, 32'h0);
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_done", clr_done, 1'b0);
        chk("rst_state", clr_state, CLR_IDLE);
        @(negedge clk);
        reset = 1'b1;

        // ---------------- vectors (first applied on reset release) ----------------
        for (int i = 0; i < 13; i++) begin
            wr_en = vt[i].wr_en; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rsv_en = vt[i].rsv_en; rsv_addr = vt[i].ra;
            rd1(vt[i].a0, vt[i].a1);
            #2;
            chk($sformatf("vec%0d_rd0", i), rd_data[31:0], vt[i].e0);
            chk($sformatf("vec%0d_rd1", i), rd_data[63:32], vt[i].e1);
            chk($sformatf("vec%0d_pend", i), pend, vt[i].ep);
            @(negedge clk);
        end
        idle1();

        // ---------------- full clear ----------------
        fill1();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        @(negedge clk);
        idle1();
        clr_req = 1'b1;
        #2;
        chk("preclr_pend", pend, 32'h10);
        @(negedge clk);
        busy_n = 0; done_n = 0; done_c = 0;
        for (int c = 1; c <= 100; c++) begin
            idle1(); rd1(5'd0, 5'd0);
            if (c == 5) begin
                rd1(5'd2, 5'd30);
                wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hBAD0_0020;
                rsv_en = 1'b1; rsv_addr = 5'd20;
            end
            #2;
            if (c == 1) chk("clr_pend_wiped", pend, 32'h0);
            if (c == 5) begin
                chk("midclr_r2", rd_data[31:0], 32'h0);
                chk("midclr_r30", rd_data[63:32], 32'h1000001E);
            end
            if (clr_done) begin done_n++; done_c = c; end
            if (!clr_busy) break;
            busy_n++;
            @(negedge clk);
        end
        idle1();
        chk("clr_busy_cycles", busy_n, 33);
        chk("clr_done_pulses", done_n, 1);
        chk("clr_done_cycle", done_c, 33);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd1(5'(2*i), 5'(2*i+1));
            #2;
            chk($sformatf("postclr_r%0d", 2*i), rd_data[31:0], 32'h0);
            chk($sformatf("postclr_r%0d", 2*i+1), rd_data[63:32], 32'h0);
            @(negedge clk);
        end
        chk("postclr_pend", pend, 32'h0);

        // ---------------- reset during clear ----------------
        fill1();
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        for (int c = 0; c < 10; c++) @(negedge clk);
        #1;
        chk("abort_pre_busy", clr_busy, 1'b1);
        reset = 1'b0;
        rd1(5'd11, 5'd31);
        #1;
        chk("abort_busy", clr_busy, 1'b0);
        chk("abort_done", clr_done, 1'b0);
        chk("abort_state", clr_state, CLR_IDLE);
        chk("abort_pend", pend, 32'h0);
        chk("abort_r11", rd_data[31:0], 32'h0);
        chk("abort_r31", rd_data[63:32], 32'h0);
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
        @(negedge clk);
        idle1(); rd1(5'd6, 5'd10);
        #2;
        chk("first_wr_r6", rd_data[31:0], 32'h66);
        chk("abort_r10", rd_data[63:32], 32'h0);
        done_n = 0; busy_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #2;
            if (clr_done) done_n++;
            if (clr_busy) busy_n++;
        end
        chk("abort_no_done", done_n, 0);
        chk("abort_no_busy", busy_n, 0);

        // ---------------- sweep configuration ----------------
        @(negedge clk);
        wr_en2 = 1'b1; wr_addr2 = 4'd5; wr_data2 = 64'hDEADBEEF;
        rd2(4'd5, 4'd5, 4'd0);
        #2;
        chk("sw_byp_p0", rd_data2[63:0], 64'hDEADBEEF);
        chk("sw_byp_p1", rd_data2[127:64], 64'hDEADBEEF);
        chk("sw_byp_p2", rd_data2[191:128], 64'h0);
        @(negedge clk);
        idle2();
        wr_en2 = 1'b1; wr_addr2 = 4'd0; wr_data2 = 64'h1234;
        rsv_en2 = 1'b1; rsv_addr2 = 4'd0;
        rd2(4'd5, 4'd5, 4'd5);
        #2;
        chk("sw_r5_p0", rd_data2[63:0], 64'hDEADBEEF);
        chk("sw_r5_p1", rd_data2[127:64], 64'hDEADBEEF);
        chk("sw_r5_p2", rd_data2[191:128], 64'hDEADBEEF);
        @(negedge clk);
        idle2();
        rsv_en2 = 1'b1; rsv_addr2 = 4'd7;
        rd2(4'd0, 4'd0, 4'd0);
        #2;
        chk("sw_r0", rd_data2[63:0], 64'h0);
        chk("sw_pend0", pend2, 16'h0);
        @(negedge clk);
        idle2();
        wr_en2 = 1'b1; wr_addr2 = 4'd7; wr_data2 = 64'h0123_4567_89AB_CDEF;
        rd2(4'd7, 4'd0, 4'd0);
        #2;
        chk("sw_pend7_set", pend2, 16'h0080);
        chk("sw_byp_r7", rd_data2[63:0], 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        idle2();
        wr_en2 = 1'b1; wr_addr2 = 4'd9; wr_data2 = 64'hFFFF_FFFF_FFFF_FFFF;
        rsv_en2 = 1'b1; rsv_addr2 = 4'd9;
        rd2(4'd9, 4'd7, 4'd0);
        #2;
        chk("sw_pend7_clr", pend2, 16'h0);
        @(negedge clk);
        idle2();
        rd2(4'd9, 4'd7, 4'd0);
        #2;
        chk("sw_pend9", pend2, 16'h0200);
        chk("sw_r9", rd_data2[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sw_r7", rd_data2[127:64], 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        for (int i = 1; i < 16; i++) begin
            wr_en2 = 1'b1; wr_addr2 = 4'(i); wr_data2 = {32'hA, 32'(i)};
            @(negedge clk);
        end
        idle2();
        clr_req2 = 1'b1;
        @(negedge clk);
        busy_n = 0; done_n = 0;
        for (int c = 1; c <= 100; c++) begin
            idle2();
            if (c == 3) begin
                wr_en2 = 1'b1; wr_addr2 = 4'd12; wr_data2 = 64'hBAD;
            end
            #2;
            if (clr_done2) done_n++;
            if (!clr_busy2) break;
            busy_n++;
            @(negedge clk);
        end
        idle2();
        chk("sw_clr_busy_cycles", busy_n, 17);
        chk("sw_clr_done_pulses", done_n, 1);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd2(4'(i), 4'(15 - i), 4'd12);
            #2;
            chk($sformatf("sw_postclr_r%0d", i), rd_data2[63:0], 64'h0);
            @(negedge clk);
        end
        chk("sw_postclr_r12", rd_data2[191:128], 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
